prf_read_arbiter: RTL and testbench



---
 rtl/prf_read_arbiter_pkg.sv | 41 ++++
 rtl/prf_read_arbiter_bank_rr_picker.sv | 65 ++++++
 rtl/prf_read_arbiter.sv | 116 +++++++++++
 tb/tb_prf_read_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prf_read_arbiter_pkg.sv
// rtl/prf_read_arbiter_pkg.sv - shared sizes, tag typedefs and index helpers for the PRF read arbiter
package prf_read_arbiter_pkg;

  localparam int PR_COUNT            = 128;
  localparam int LOG_PR_COUNT        = $clog2(PR_COUNT);
  localparam int PRF_BANK_COUNT      = 4;
  localparam int LOG_PRF_BANK_COUNT  = $clog2(PRF_BANK_COUNT);
  localparam int PRF_ROW_COUNT       = PR_COUNT / PRF_BANK_COUNT;
  localparam int LOG_PRF_ROW_COUNT   = $clog2(PRF_ROW_COUNT);
  localparam int PRF_RR_COUNT        = 14;
  localparam int LOG_PRF_RR_COUNT    = $clog2(PRF_RR_COUNT);
  localparam int PRF_READ_PORT_COUNT = 2;
  localparam int PERF_COUNT_WIDTH    = 32;

  typedef logic [LOG_PR_COUNT-1:0]       pr_tag_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0] bank_idx_t;
  typedef logic [LOG_PRF_ROW_COUNT-1:0]  row_idx_t;
  typedef logic [LOG_PRF_RR_COUNT-1:0]   rr_idx_t;
  typedef logic [LOG_PRF_RR_COUNT:0]     rr_sum_t;
  typedef logic [PRF_RR_COUNT-1:0]       rr_mask_t;

  // Requester index addition modulo PRF_RR_COUNT; both operands are already in range.
  function automatic rr_idx_t rr_wrap_add(rr_idx_t a, rr_idx_t b);
    rr_sum_t sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= rr_sum_t'(PRF_RR_COUNT)) begin
      sum = sum - rr_sum_t'(PRF_RR_COUNT);
    end
    return sum[LOG_PRF_RR_COUNT-1:0];
  endfunction

  // Low tag bits select the bank so consecutive PRs spread across banks.
  function automatic bank_idx_t pr_bank(pr_tag_t pr);
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

  function automatic row_idx_t pr_row(pr_tag_t pr);
    return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
  endfunction

endpackage

// File: rtl/prf_read_arbiter_bank_rr_picker.sv
// rtl/prf_read_arbiter_bank_rr_picker.sv - module prf_bank_rr_picker: two-port rotating pick with duplicate-PR merge for one bank
module prf_bank_rr_picker
  import prf_read_arbiter_pkg::*;
(
  input  logic [PRF_RR_COUNT-1:0]                                   valid_i,
  input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]                 pr_i,
  input  logic [LOG_PRF_RR_COUNT-1:0]                               ptr_i,
  output logic [PRF_READ_PORT_COUNT-1:0]                            port_valid_o,
  output logic [PRF_READ_PORT_COUNT-1:0][LOG_PRF_ROW_COUNT-1:0]     port_row_o,
  output logic [PRF_READ_PORT_COUNT-1:0][PRF_RR_COUNT-1:0]          port_mask_o,
  output logic [PRF_RR_COUNT-1:0]                                   ack_o,
  output logic [LOG_PRF_RR_COUNT-1:0]                               next_ptr_o
);

  logic    found0, found1;
  rr_idx_t win0, win1, idx;
  pr_tag_t pr0, pr1;

  // Circular scan from ptr: first valid requester takes port 0, next one with a different PR takes port 1.
  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    win0   = '0;
    win1   = '0;
    pr0    = '0;
    pr1    = '0;
    idx    = '0;
    for (int k = 0; k < PRF_RR_COUNT; k++) begin
      idx = rr_wrap_add(ptr_i, rr_idx_t'(k));
      if (valid_i[idx]) begin
        if (!found0) begin
          found0 = 1'b1;
          win0   = idx;
          pr0    = pr_i[idx];
        end else if (!found1 && (pr_i[idx] != pr0)) begin
          found1 = 1'b1;
          win1   = idx;
          pr1    = pr_i[idx];
        end
      end
    end
  end

  // Every requester reading a winning PR rides on that port; pointer moves past the last real winner only.
  always_comb begin
    port_mask_o = '0;
    for (int i = 0; i < PRF_RR_COUNT; i++) begin
      port_mask_o[0][i] = valid_i[i] && found0 && (pr_i[i] == pr0);
      port_mask_o[1][i] = valid_i[i] && found1 && (pr_i[i] == pr1);
    end
    ack_o        = port_mask_o[0] | port_mask_o[1];
    port_valid_o = {found1, found0};
    port_row_o   = '0;
    if (found0) port_row_o[0] = pr_row(pr0);
    if (found1) port_row_o[1] = pr_row(pr1);
    if (found1) begin
      next_ptr_o = rr_wrap_add(win1, rr_idx_t'(1));
    end else if (found0) begin
      next_ptr_o = rr_wrap_add(win0, rr_idx_t'(1));
    end else begin
      next_ptr_o = ptr_i;
    end
  end

endmodule

// File: rtl/prf_read_arbiter.sv
// rtl/prf_read_arbiter.sv - per-bank PRF read-port arbiter top; optional PRF_READ_ARB_PERF_EN adds per-bank conflict counters
module prf_read_arbiter
  import prf_read_arbiter_pkg::*;
(
  input  logic                                                                     CLK,
  input  logic                                                                     nRST,
  input  logic [PRF_RR_COUNT-1:0]                                                  req_valid_by_rr,
  input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]                                req_pr_by_rr,
  output logic [PRF_RR_COUNT-1:0]                                                  req_ack_by_rr,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                       bank_read_valid_by_bank_by_port,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][LOG_PRF_ROW_COUNT-1:0] bank_read_row_by_bank_by_port,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][PRF_RR_COUNT-1:0]     bank_read_mask_by_bank_by_port
`ifdef PRF_READ_ARB_PERF_EN
  ,
  output logic [PRF_BANK_COUNT-1:0][PERF_COUNT_WIDTH-1:0]                          perf_conflict_count_by_bank
`endif
);

  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0]                                  valid_to_bank;
  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0]                                  ack_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_PRF_RR_COUNT-1:0]                              next_ptr_by_bank;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                           pick_valid;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][LOG_PRF_ROW_COUNT-1:0]    pick_row;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][PRF_RR_COUNT-1:0]         pick_mask;
  logic [PRF_RR_COUNT-1:0]                                                      ack_any;

  logic [PRF_BANK_COUNT-1:0][LOG_PRF_RR_COUNT-1:0]                              ptr_d, ptr_q;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                           read_valid_d, read_valid_q;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][LOG_PRF_ROW_COUNT-1:0]    read_row_d, read_row_q;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][PRF_RR_COUNT-1:0]         read_mask_d, read_mask_q;

  // Steer each valid request to the bank named by its low tag bits.
  always_comb begin
    valid_to_bank = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_RR_COUNT; i++) begin
        valid_to_bank[b][i] = req_valid_by_rr[i] && (pr_bank(req_pr_by_rr[i]) == bank_idx_t'(b));
      end
    end
  end

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
    prf_bank_rr_picker u_picker (
      .valid_i      (valid_to_bank[b]),
      .pr_i         (req_pr_by_rr),
      .ptr_i        (ptr_q[b]),
      .port_valid_o (pick_valid[b]),
      .port_row_o   (pick_row[b]),
      .port_mask_o  (pick_mask[b]),
      .ack_o        (ack_by_bank[b]),
      .next_ptr_o   (next_ptr_by_bank[b])
    );
  end

  // Banks serve disjoint requesters, so the per-bank acks simply OR together; acks are held off during reset.
  always_comb begin
    ack_any = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      ack_any = ack_any | ack_by_bank[b];
    end
    req_ack_by_rr = nRST ? ack_any : '0;
  end

  // Next-state for the pointers and the registered bank read interface.
  always_comb begin
    ptr_d        = next_ptr_by_bank;
    read_valid_d = pick_valid;
    read_row_d   = pick_row;
    read_mask_d  = pick_mask;
  end

  // Pointer and bank read registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q        <= '0;
      read_valid_q <= '0;
      read_row_q   <= '0;
      read_mask_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      read_valid_q <= read_valid_d;
      read_row_q   <= read_row_d;
      read_mask_q  <= read_mask_d;
    end
  end

  assign bank_read_valid_by_bank_by_port = read_valid_q;
  assign bank_read_row_by_bank_by_port   = read_row_q;
  assign bank_read_mask_by_bank_by_port  = read_mask_q;

`ifdef PRF_READ_ARB_PERF_EN
  logic [PRF_BANK_COUNT-1:0][PERF_COUNT_WIDTH-1:0] conflict_count_d, conflict_count_q;

  // Count cycles where some request to the bank was left waiting, saturating at all-ones.
  always_comb begin
    conflict_count_d = conflict_count_q;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      if ((|(valid_to_bank[b] & ~ack_by_bank[b])) && (conflict_count_q[b] != '1)) begin
        conflict_count_d[b] = conflict_count_q[b] + 1'b1;
      end
    end
  end

  // Conflict counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      conflict_count_q <= '0;
    end else begin
      conflict_count_q <= conflict_count_d;
    end
  end

  assign perf_conflict_count_by_bank = conflict_count_q;
`endif

endmodule

// File: tb/tb_prf_read_arbiter.sv
// tb/tb_prf_read_arbiter.sv - scoreboard bench for prf_read_arbiter with directed vectors
module tb_prf_read_arbiter;
  import prf_read_arbiter_pkg::*;

  logic CLK;
  logic nRST;
  logic [13:0]            req_valid;
  logic [13:0][6:0]       req_pr;
  logic [13:0]            ack;
  logic [3:0][1:0]        rd_valid;
  logic [3:0][1:0][4:0]   rd_row;
  logic [3:0][1:0][13:0]  rd_mask;
`ifdef PRF_READ_ARB_PERF_EN
  logic [3:0][31:0]       perf_cnt;
`endif

  prf_read_arbiter dut (
    .CLK                             (CLK),
    .nRST                            (nRST),
    .req_valid_by_rr                 (req_valid),
    .req_pr_by_rr                    (req_pr),
    .req_ack_by_rr                   (ack),
    .bank_read_valid_by_bank_by_port (rd_valid),
    .bank_read_row_by_bank_by_port   (rd_row),
    .bank_read_mask_by_bank_by_port  (rd_mask)
`ifdef PRF_READ_ARB_PERF_EN
    ,
    .perf_conflict_count_by_bank     (perf_cnt)
`endif
  );

  typedef struct {
    int          bank;
    int          port;
    logic [4:0]  row;
    logic [13:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic sb_skip = 1'b0;
  logic [13:0]      drv_valid;
  logic [13:0][6:0] drv_pr;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every registered port grant must match the oldest expected grant; idle ports must be all zero.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST && !sb_skip) begin
      for (int b = 0; b < 4; b++) begin
        for (int p = 0; p < 2; p++) begin
          n_chk++;
          if (rd_valid[b][p]) begin
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_grant: bank %0d port %0d row %0d mask %h, none expected", b, p, rd_row[b][p], rd_mask[b][p]);
            end else begin
              e = exp_q.pop_front();
              if (e.bank != b || e.port != p || e.row != rd_row[b][p] || e.mask != rd_mask[b][p]) begin
                n_fail++;
                $display("FAIL grant: got bank %0d port %0d row %0d mask %h, want bank %0d port %0d row %0d mask %h",
                         b, p, rd_row[b][p], rd_mask[b][p], e.bank, e.port, e.row, e.mask);
              end
            end
          end else if (rd_row[b][p] != '0 || rd_mask[b][p] != '0) begin
            n_fail++;
            $display("FAIL idle_port_zero: bank %0d port %0d row %0d mask %h, want 0 0", b, p, rd_row[b][p], rd_mask[b][p]);
          end
        end
      end
    end
  end

  task automatic clear_req();
    drv_valid = '0;
    drv_pr    = '0;
  endtask

  task automatic set_req(input int rr, input logic [6:0] pr);
    drv_valid[rr] = 1'b1;
    drv_pr[rr]    = pr;
  endtask

  task automatic expect_port(input int b, input int p, input logic [4:0] row, input logic [13:0] mask);
    exp_t e;
    e.bank = b; e.port = p; e.row = row; e.mask = mask;
    exp_q.push_back(e);
  endtask

  // One cycle: apply drive just after the edge, then check the combinational ack.
  task automatic step(input logic chk, input logic [13:0] exp_ack);
    @(posedge CLK);
    #1;
    req_valid = drv_valid;
    req_pr    = drv_pr;
    #2;
    if (chk) begin
      n_chk++;
      if (ack !== exp_ack) begin
        n_fail++;
        $display("FAIL ack: got %h want %h", ack, exp_ack);
      end
    end
  endtask

  task automatic check_ptr(input int b, input logic [3:0] want);
    n_chk++;
    if (dut.ptr_q[b] !== want) begin
      n_fail++;
      $display("FAIL ptr%0d: got %0d want %0d", b, dut.ptr_q[b], want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_chk++;
    if (ack !== '0 || rd_valid !== '0 || rd_row !== '0 || rd_mask !== '0) begin
      n_fail++;
      $display("FAIL %s: got ack %h valid %h row %h mask %h, want all 0", name, ack, rd_valid, rd_row, rd_mask);
    end
  endtask

  initial begin
    nRST = 1'b0;
    req_valid = '0;
    req_pr = '0;
    clear_req();

    // Reset held with every requester active.
    for (int i = 0; i < 14; i++) set_req(i, 7'(i * 5));
    repeat (3) step(1'b1, 14'h0000);
    check_outputs_zero("reset_outputs");
    clear_req();
    step(1'b1, 14'h0000);
    @(negedge CLK);
    #2 nRST = 1'b1;
    for (int b = 0; b < 4; b++) check_ptr(b, 4'd0);

`ifdef PRF_READ_ARB_PERF_EN
    // Three distinct bank-3 PRs: one always loses, so bank 3 counts every cycle.
    sb_skip = 1'b1;
    clear_req();
    set_req(0, 7'h03); set_req(1, 7'h07); set_req(2, 7'h0B);
    repeat (6) step(1'b0, 14'h0000);
    clear_req();
    step(1'b1, 14'h0000);
    n_chk++;
    if (perf_cnt[3] !== 32'd6 || perf_cnt[0] !== 0 || perf_cnt[1] !== 0 || perf_cnt[2] !== 0) begin
      n_fail++;
      $display("FAIL perf_count: got %0d %0d %0d %0d want 0 0 0 6", perf_cnt[0], perf_cnt[1], perf_cnt[2], perf_cnt[3]);
    end
    @(negedge CLK);
    #1 nRST = 1'b0;
    sb_skip = 1'b0;
    @(negedge CLK);
    #2 nRST = 1'b1;
    n_chk++;
    if (perf_cnt !== '0) begin
      n_fail++;
      $display("FAIL perf_reset: got %h want 0", perf_cnt);
    end
`endif

    // Single request to bank 1.
    clear_req(); set_req(3, 7'h05);
    step(1'b1, 14'h0008); expect_port(1, 0, 5'd1, 14'h0008);
    clear_req(); step(1'b1, 14'h0000);
    check_ptr(1, 4'd4);

    // Three distinct bank-0 PRs: two this cycle, the third next cycle.
    clear_req(); set_req(0, 7'h00); set_req(1, 7'h04); set_req(2, 7'h08);
    step(1'b1, 14'h0003); expect_port(0, 0, 5'd0, 14'h0001); expect_port(0, 1, 5'd1, 14'h0002);
    clear_req(); set_req(2, 7'h08);
    step(1'b1, 14'h0004); expect_port(0, 0, 5'd2, 14'h0004);
    check_ptr(0, 4'd2);
    clear_req(); step(1'b1, 14'h0000);
    check_ptr(0, 4'd3);

    // Duplicate PR merge.
    clear_req(); set_req(5, 7'h08); set_req(9, 7'h08); set_req(6, 7'h0C);
    step(1'b1, 14'h0260); expect_port(0, 0, 5'd2, 14'h0220); expect_port(0, 1, 5'd3, 14'h0040);
    clear_req(); step(1'b1, 14'h0000);
    check_ptr(0, 4'd7);

    // Pointer wrap in bank 2.
    clear_req(); set_req(12, 7'h02);
    step(1'b1, 14'h1000); expect_port(2, 0, 5'd0, 14'h1000);
    clear_req(); set_req(13, 7'h02); set_req(0, 7'h06);
    step(1'b1, 14'h2001); expect_port(2, 0, 5'd0, 14'h2000); expect_port(2, 1, 5'd1, 14'h0001);
    check_ptr(2, 4'd13);
    clear_req(); step(1'b1, 14'h0000);
    check_ptr(2, 4'd1);

    // All requesters read the same PR: one port, full mask.
    clear_req();
    for (int i = 0; i < 14; i++) set_req(i, 7'h01);
    step(1'b1, 14'h3FFF); expect_port(1, 0, 5'd0, 14'h3FFF);
    clear_req(); step(1'b1, 14'h0000);
    check_ptr(1, 4'd5);

    // Two banks at once, bank 3 oversubscribed.
    clear_req(); set_req(7, 7'h0F); set_req(8, 7'h13); set_req(10, 7'h17); set_req(11, 7'h09);
    step(1'b1, 14'h0980);
    expect_port(1, 0, 5'd2, 14'h0800); expect_port(3, 0, 5'd3, 14'h0080); expect_port(3, 1, 5'd4, 14'h0100);
    clear_req(); set_req(10, 7'h17);
    step(1'b1, 14'h0400); expect_port(3, 0, 5'd5, 14'h0400);
    check_ptr(3, 4'd9);
    check_ptr(1, 4'd12);
    clear_req(); step(1'b1, 14'h0000);
    check_ptr(3, 4'd11);

    // Async reset during a granting cycle discards that grant.
    clear_req(); step(1'b1, 14'h0000);
    set_req(4, 7'h11);
    step(1'b1, 14'h0010);
    #1 nRST = 1'b0;
    #1 check_outputs_zero("async_reset");
    clear_req();
    step(1'b0, 14'h0000);
    @(negedge CLK);
    #2 nRST = 1'b1;
    for (int b = 0; b < 4; b++) check_ptr(b, 4'd0);

    repeat (3) step(1'b1, 14'h0000);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
